debug_loader: RTL and testbench

Host-side control unit for the MIPS pipeline, sitting between the UART receive path and the `pipeline` top. It consumes a byte stream of host commands, packs program bytes into 32-bit instructions and writes them into instruction memory. It drives the pipeline's `i_reset` and `i_valid` inputs to run a loaded program to halt or single-step it. It replaces the fixed stimulus of the simulation bench on hardware.

---
 rtl/debug_loader_pkg.sv | 41 ++++
 rtl/debug_loader_byte_packer.sv | 60 ++++++
 rtl/debug_loader.sv | 169 ++++++++++++++++
 tb/tb_debug_loader.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_loader_pkg.sv
// ============================================================================
//  Module      : debug_loader_pkg
//  Description : Host command codes, loader FSM states and the clogb2 helper
//                shared by the debug loader and its byte packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package debug_loader_pkg;

    localparam logic [7:0] c_cmd_load = 8'h4C;
    localparam logic [7:0] c_cmd_run  = 8'h52;
    localparam logic [7:0] c_cmd_step = 8'h53;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_CNT  = 3'd1,
        ST_LOAD_DATA = 3'd2,
        ST_RUN_RST   = 3'd3,
        ST_RUN       = 3'd4,
        ST_STEP      = 3'd5
    } state_t;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clogb2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if (((value - 1) >> i) != 0) begin
                res = i + 1;
            end
        end
        if (res == 0) begin
            res = 1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/debug_loader_byte_packer.sv
// ============================================================================
//  Module      : byte_packer
//  Description : Shifts host bytes big-endian into an instruction word and
//                flags the word for one cycle once it is complete.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_packer
    import debug_loader_pkg::*;
#(
    parameter int NB_INSTR = 32,
    parameter int NB_BYTE  = 8
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_clear,
    input  logic                i_byte_valid,
    input  logic [NB_BYTE-1:0]  i_byte,
    output logic [NB_INSTR-1:0] o_word,
    output logic                o_word_valid,
    output logic                o_last_byte
);

    localparam int c_n_bytes = NB_INSTR / NB_BYTE;
    localparam int c_cnt_w   = clogb2(c_n_bytes);

    logic [c_cnt_w-1:0]  r_cnt;
    logic [NB_INSTR-1:0] r_word;
    logic                r_word_valid;
    logic                w_last_byte;

    // High in the cycle the final byte of a word is presented.
    assign w_last_byte = i_byte_valid && (r_cnt == c_cnt_w'(c_n_bytes - 1));

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else if (i_clear) begin
            r_cnt        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= w_last_byte;
            if (i_byte_valid) begin
                r_word <= {r_word[NB_INSTR-NB_BYTE-1:0], i_byte};
                r_cnt  <= w_last_byte ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;
    assign o_last_byte  = w_last_byte;

endmodule

`default_nettype wire

// File: rtl/debug_loader.sv
// ============================================================================
//  Module      : debug_loader
//  Description : Host command decoder: loads instruction memory from a byte
//                stream and runs or single-steps the MIPS pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_loader
    import debug_loader_pkg::*;
#(
    parameter int NB_INSTR           = 32,
    parameter int N_ADDR             = 32,
    parameter int LOG2_N_INSMEM_ADDR = 5,
    parameter int NB_BYTE            = 8
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [NB_BYTE-1:0]            i_rx_data,
    input  logic                          i_rx_valid,
    input  logic                          i_halt,
    output logic                          o_imem_wr_en,
    output logic [LOG2_N_INSMEM_ADDR-1:0] o_imem_addr,
    output logic [NB_INSTR-1:0]           o_imem_data,
    output logic                          o_pipe_reset,
    output logic                          o_pipe_valid,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam int                 c_cnt_w     = clogb2(N_ADDR + 1);
    localparam logic [c_cnt_w-1:0] c_max_words = c_cnt_w'(N_ADDR);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [c_cnt_w-1:0]              r_word_cnt;
    logic [c_cnt_w-1:0]              w_word_cnt_nxt;
    logic [c_cnt_w-1:0]              r_word_idx;
    logic [c_cnt_w-1:0]              w_word_idx_nxt;
    logic [LOG2_N_INSMEM_ADDR-1:0]   r_addr;
    logic [LOG2_N_INSMEM_ADDR-1:0]   w_addr_nxt;
    logic                            r_pipe_reset;
    logic                            w_pipe_reset_nxt;
    logic                            r_pipe_valid;
    logic                            w_pipe_valid_nxt;
    logic                            r_done;
    logic                            w_done_nxt;
    logic                            r_busy;
    logic                            w_pack_clear;
    logic                            w_pack_valid;
    logic                            w_last_byte;

    assign w_pack_valid = i_rx_valid && (r_state == ST_LOAD_DATA);

    byte_packer #(
        .NB_INSTR (NB_INSTR),
        .NB_BYTE  (NB_BYTE)
    ) u_byte_packer (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_clear      (w_pack_clear),
        .i_byte_valid (w_pack_valid),
        .i_byte       (i_rx_data),
        .o_word       (o_imem_data),
        .o_word_valid (o_imem_wr_en),
        .o_last_byte  (w_last_byte)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_word_cnt_nxt   = r_word_cnt;
        w_word_idx_nxt   = r_word_idx;
        w_addr_nxt       = r_addr;
        w_pipe_reset_nxt = 1'b0;
        w_pipe_valid_nxt = 1'b0;
        w_done_nxt       = 1'b0;
        w_pack_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == NB_BYTE'(c_cmd_load)) begin
                        w_state_nxt = ST_LOAD_CNT;
                    end else if (i_rx_data == NB_BYTE'(c_cmd_run)) begin
                        w_state_nxt      = ST_RUN_RST;
                        w_pipe_reset_nxt = 1'b1;
                    end else if (i_rx_data == NB_BYTE'(c_cmd_step)) begin
                        w_state_nxt      = ST_STEP;
                        w_pipe_valid_nxt = 1'b1;
                    end
                end
            end
            ST_LOAD_CNT: begin
                if (i_rx_valid) begin
                    if (i_rx_data == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt    = ST_LOAD_DATA;
                        w_pack_clear   = 1'b1;
                        w_word_idx_nxt = '0;
                        w_addr_nxt     = '0;
                        w_word_cnt_nxt = (int'(i_rx_data) > N_ADDR) ?
                                         c_max_words : c_cnt_w'(i_rx_data);
                    end
                end
            end
            ST_LOAD_DATA: begin
                // Address is latched with the word so it is valid during the strobe.
                if (w_last_byte) begin
                    w_addr_nxt     = r_word_idx[LOG2_N_INSMEM_ADDR-1:0];
                    w_word_idx_nxt = r_word_idx + c_cnt_w'(1);
                    if ((r_word_idx + c_cnt_w'(1)) == r_word_cnt) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_RUN_RST: begin
                w_state_nxt      = ST_RUN;
                w_pipe_valid_nxt = 1'b1;
            end
            ST_RUN: begin
                if (i_halt) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_pipe_valid_nxt = 1'b1;
                end
            end
            ST_STEP: begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_word_cnt   <= '0;
            r_word_idx   <= '0;
            r_addr       <= '0;
            r_pipe_reset <= 1'b0;
            r_pipe_valid <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_word_cnt   <= w_word_cnt_nxt;
            r_word_idx   <= w_word_idx_nxt;
            r_addr       <= w_addr_nxt;
            r_pipe_reset <= w_pipe_reset_nxt;
            r_pipe_valid <= w_pipe_valid_nxt;
            r_done       <= w_done_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

    assign o_imem_addr  = r_addr;
    assign o_pipe_reset = r_pipe_reset;
    assign o_pipe_valid = r_pipe_valid;
    assign o_done       = r_done;
    assign o_busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_debug_loader.sv
// ============================================================================
//  Module      : tb_debug_loader
//  Description : Self-checking bench for debug_loader: vector table, directed
//                timing sequences and randomized commands against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debug_loader;

    logic        tb_clock_i = 1'b0;
    logic        rst_n      = 1'b0;
    logic [7:0]  rx_data    = '0;
    logic        rx_valid   = 1'b0;
    logic        halt       = 1'b0;
    logic        imem_wr_en;
    logic [4:0]  imem_addr;
    logic [31:0] imem_data;
    logic        pipe_reset;
    logic        pipe_valid;
    logic        busy;
    logic        done;

    always #5 tb_clock_i = ~tb_clock_i;

    debug_loader #(
        .NB_INSTR           (32),
        .N_ADDR             (32),
        .LOG2_N_INSMEM_ADDR (5),
        .NB_BYTE            (8)
    ) dut (
        .i_clock      (tb_clock_i),
        .i_reset      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .i_halt       (halt),
        .o_imem_wr_en (imem_wr_en),
        .o_imem_addr  (imem_addr),
        .o_imem_data  (imem_data),
        .o_pipe_reset (pipe_reset),
        .o_pipe_valid (pipe_valid),
        .o_busy       (busy),
        .o_done       (done)
    );

    int errors = 0;
    int checks = 0;

    // Observed activity, sampled on the falling edge.
    logic [4:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int n_done = 0, n_done_wr = 0, n_preset = 0, n_pv = 0, n_pv_rise = 0;
    logic pv_q = 1'b0;
    int s_done, s_done_wr, s_preset, s_pv, s_pv_rise;

    always @(negedge tb_clock_i) begin
        if (imem_wr_en) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_data);
        end
        if (done) n_done++;
        if (done && imem_wr_en) n_done_wr++;
        if (pipe_reset) n_preset++;
        if (pipe_valid) n_pv++;
        if (pipe_valid && !pv_q) n_pv_rise++;
        pv_q = pipe_valid;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic snap();
        wr_addr_q.delete();
        wr_data_q.delete();
        s_done = n_done; s_done_wr = n_done_wr; s_preset = n_preset;
        s_pv = n_pv; s_pv_rise = n_pv_rise;
    endtask

    task automatic check_counts(input string name, input int e_done, input int e_dw,
                                input int e_preset, input int e_pv);
        check({name, " done"},     64'(n_done - s_done),       64'(e_done));
        check({name, " done_wr"},  64'(n_done_wr - s_done_wr), 64'(e_dw));
        check({name, " preset"},   64'(n_preset - s_preset),   64'(e_preset));
        check({name, " pv_cyc"},   64'(n_pv - s_pv),           64'(e_pv));
        check({name, " busy_end"}, 64'(busy),                  64'(0));
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge tb_clock_i);
        rx_valid = 1'b0;
        repeat (gap) @(negedge tb_clock_i);
    endtask

    task automatic settle();
        repeat (8) @(negedge tb_clock_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge tb_clock_i);
        rst_n = 1'b1;
        @(negedge tb_clock_i);
    endtask

    typedef struct {
        logic [95:0] bytes;   // first byte in bits 95:88
        int          n;
        int          gap;
        int          e_wr;
        logic [31:0] e_d0;
        logic [31:0] e_dl;
        int          e_done;
        int          e_dw;
        int          e_preset;
        int          e_pv;
    } vec_t;

    vec_t        tv[8];
    logic [31:0] exp_d[$];
    logic [31:0] word;
    logic [7:0]  b;
    bit          ok;
    int          nw, g, d;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{bytes: 96'h4C_02_01_02_03_04_AA_BB_CC_DD_00_00, n: 10, gap: 0, e_wr: 2,
                  e_d0: 32'h01020304, e_dl: 32'hAABBCCDD, e_done: 1, e_dw: 1, e_preset: 0, e_pv: 0};
        tv[1] = '{bytes: 96'h4C_00_00_00_00_00_00_00_00_00_00_00, n: 2, gap: 0, e_wr: 0,
                  e_d0: 0, e_dl: 0, e_done: 0, e_dw: 0, e_preset: 0, e_pv: 0};
        tv[2] = '{bytes: 96'h53_53_53_00_00_00_00_00_00_00_00_00, n: 3, gap: 3, e_wr: 0,
                  e_d0: 0, e_dl: 0, e_done: 3, e_dw: 0, e_preset: 0, e_pv: 3};
        tv[3] = '{bytes: 96'h53_53_53_00_00_00_00_00_00_00_00_00, n: 3, gap: 0, e_wr: 0,
                  e_d0: 0, e_dl: 0, e_done: 2, e_dw: 0, e_preset: 0, e_pv: 2};
        tv[4] = '{bytes: 96'h00_FF_41_4D_54_00_00_00_00_00_00_00, n: 5, gap: 1, e_wr: 0,
                  e_d0: 0, e_dl: 0, e_done: 0, e_dw: 0, e_preset: 0, e_pv: 0};
        tv[5] = '{bytes: 96'h4C_01_11_22_33_44_00_00_00_00_00_00, n: 6, gap: 2, e_wr: 1,
                  e_d0: 32'h11223344, e_dl: 32'h11223344, e_done: 1, e_dw: 1, e_preset: 0, e_pv: 0};
        tv[6] = '{bytes: 96'h4C_01_DE_AD_BE_EF_53_00_00_00_00_00, n: 7, gap: 0, e_wr: 1,
                  e_d0: 32'hDEADBEEF, e_dl: 32'hDEADBEEF, e_done: 2, e_dw: 1, e_preset: 0, e_pv: 1};
        tv[7] = '{bytes: 96'h4C_00_53_00_00_00_00_00_00_00_00_00, n: 3, gap: 0, e_wr: 0,
                  e_d0: 0, e_dl: 0, e_done: 1, e_dw: 0, e_preset: 0, e_pv: 1};

        // Reset: every output low for ten idle cycles.
        repeat (2) @(negedge tb_clock_i);
        #1;
        check("in_reset outputs", {imem_wr_en, imem_addr, imem_data, pipe_reset, pipe_valid, busy, done}, 64'd0);
        rst_n = 1'b1;
        @(negedge tb_clock_i);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if ({imem_wr_en, imem_addr, imem_data, pipe_reset, pipe_valid, busy, done} !== '0) ok = 1'b0;
            @(negedge tb_clock_i);
        end
        check("post_reset idle outputs", 64'(ok), 64'd1);

        // Vector table.
        for (int v = 0; v < 8; v++) begin
            snap();
            for (int j = 0; j < tv[v].n; j++) begin
                send_byte(tv[v].bytes[95-8*j -: 8], tv[v].gap);
            end
            settle();
            check($sformatf("vec%0d writes", v), 64'(wr_data_q.size()), 64'(tv[v].e_wr));
            if (tv[v].e_wr > 0 && wr_data_q.size() == tv[v].e_wr) begin
                check($sformatf("vec%0d addr0", v), 64'(wr_addr_q[0]), 64'd0);
                check($sformatf("vec%0d data0", v), 64'(wr_data_q[0]), 64'(tv[v].e_d0));
                check($sformatf("vec%0d addrN", v), 64'(wr_addr_q[tv[v].e_wr-1]), 64'(tv[v].e_wr - 1));
                check($sformatf("vec%0d dataN", v), 64'(wr_data_q[tv[v].e_wr-1]), 64'(tv[v].e_dl));
            end
            check_counts($sformatf("vec%0d", v), tv[v].e_done, tv[v].e_dw, tv[v].e_preset, tv[v].e_pv);
        end

        // Write strobe latency: one cycle after the fourth byte.
        snap();
        send_byte(8'h4C, 0); send_byte(8'h01, 0);
        send_byte(8'h0A, 0); send_byte(8'h0B, 0); send_byte(8'h0C, 0);
        check("lat before_last wr_en", 64'(imem_wr_en), 64'd0);
        send_byte(8'h0D, 0);
        check("lat write strobe", {imem_wr_en, done, imem_addr, imem_data}, {1'b1, 1'b1, 5'd0, 32'h0A0B0C0D});
        @(negedge tb_clock_i);
        check("lat strobe_end", {imem_wr_en, done, busy}, 64'd0);

        // Clamp: 64 words requested, only 32 written, tail bytes are non-commands.
        snap();
        exp_d.delete();
        send_byte(8'h4C, 0); send_byte(8'h40, 0);
        for (int w = 0; w < 64; w++) begin
            for (int k = 0; k < 4; k++) begin
                do b = 8'($urandom); while (b == 8'h4C || b == 8'h52 || b == 8'h53);
                word[31-8*k -: 8] = b;
                send_byte(b, 0);
            end
            if (w < 32) exp_d.push_back(word);
        end
        settle();
        check("clamp writes", 64'(wr_data_q.size()), 64'd32);
        ok = (wr_data_q.size() == 32);
        for (int i = 0; i < 32 && i < wr_data_q.size(); i++) begin
            if (wr_addr_q[i] !== 5'(i) || wr_data_q[i] !== exp_d[i]) ok = 1'b0;
        end
        check("clamp contents", 64'(ok), 64'd1);
        check_counts("clamp", 1, 1, 0, 0);

        // Run with a dropped step command mid-run.
        snap();
        send_byte(8'h52, 0);
        check("run reset pulse", {pipe_reset, pipe_valid, busy}, {1'b1, 1'b0, 1'b1});
        @(negedge tb_clock_i);
        check("run valid rise", {pipe_reset, pipe_valid}, {1'b0, 1'b1});
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin rx_data = 8'h53; rx_valid = 1'b1; end
            else rx_valid = 1'b0;
            @(negedge tb_clock_i);
            if (!pipe_valid) ok = 1'b0;
        end
        check("run valid held", 64'(ok), 64'd1);
        halt = 1'b1;
        @(negedge tb_clock_i);
        halt = 1'b0;
        check("run halt drop", {pipe_valid, done}, {1'b0, 1'b1});
        settle();
        check_counts("run", 1, 0, 1, 21);
        check("run single rise", 64'(n_pv_rise - s_pv_rise), 64'd1);

        // Halt already high when RUN is entered.
        snap();
        send_byte(8'h52, 0);
        halt = 1'b1;
        @(negedge tb_clock_i);
        check("early_halt valid", 64'(pipe_valid), 64'd1);
        @(negedge tb_clock_i);
        halt = 1'b0;
        check("early_halt drop", {pipe_valid, done}, {1'b0, 1'b1});
        settle();
        check_counts("early_halt", 1, 0, 1, 1);

        // Reset mid-run drops valid at once.
        send_byte(8'h52, 3);
        rst_n = 1'b0;
        #1;
        check("rst_run outputs", {pipe_valid, busy, pipe_reset, done}, 64'd0);
        @(negedge tb_clock_i);
        rst_n = 1'b1;
        @(negedge tb_clock_i);

        // Reset after 6 of 8 load bytes, then a fresh one-word load.
        send_byte(8'h4C, 0); send_byte(8'h02, 0);
        for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), 0);
        rst_n = 1'b0;
        #1;
        check("rst_load outputs", {imem_wr_en, imem_addr, busy, done}, 64'd0);
        @(negedge tb_clock_i);
        rst_n = 1'b1;
        @(negedge tb_clock_i);
        snap();
        send_byte(8'h4C, 0); send_byte(8'h01, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        settle();
        check("rst_load writes", 64'(wr_data_q.size()), 64'd1);
        if (wr_data_q.size() == 1) check("rst_load word", {wr_addr_q[0], wr_data_q[0]}, {5'd0, 32'h11223344});
        check_counts("rst_load", 1, 1, 0, 0);

        // Randomized commands against a transaction-level model.
        for (int it = 0; it < 30; it++) begin
            snap();
            exp_d.delete();
            case ($urandom_range(0, 2))
                0: begin
                    nw = $urandom_range(1, 8);
                    g  = $urandom_range(0, 2);
                    send_byte(8'h4C, g); send_byte(8'(nw), g);
                    for (int w = 0; w < nw; w++) begin
                        word = $urandom;
                        exp_d.push_back(word);
                        for (int k = 0; k < 4; k++) send_byte(word[31-8*k -: 8], g);
                    end
                    settle();
                    check($sformatf("rnd%0d writes", it), 64'(wr_data_q.size()), 64'(nw));
                    ok = (wr_data_q.size() == nw);
                    for (int i = 0; i < nw && i < wr_data_q.size(); i++) begin
                        if (wr_addr_q[i] !== 5'(i) || wr_data_q[i] !== exp_d[i]) ok = 1'b0;
                    end
                    check($sformatf("rnd%0d contents", it), 64'(ok), 64'd1);
                    check_counts($sformatf("rnd%0d load", it), 1, 1, 0, 0);
                end
                1: begin
                    send_byte(8'h53, 0);
                    settle();
                    check_counts($sformatf("rnd%0d step", it), 1, 0, 0, 1);
                end
                default: begin
                    send_byte(8'h52, 0);
                    ok = 1'b0;
                    for (int t = 0; t < 5; t++) begin
                        if (pipe_valid) begin ok = 1'b1; break; end
                        @(negedge tb_clock_i);
                    end
                    check($sformatf("rnd%0d run start", it), 64'(ok), 64'd1);
                    d = $urandom_range(0, 12);
                    repeat (d) @(negedge tb_clock_i);
                    halt = 1'b1;
                    @(negedge tb_clock_i);
                    halt = 1'b0;
                    settle();
                    check_counts($sformatf("rnd%0d run", it), 1, 0, 1, d + 1);
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
